// File: rtl/mem_scan_reader.sv
// mem_scan_reader
//   Read-only engine for the data memory. It walks an inclusive address range
//   (the range may wrap past the top of memory) and issues synchronous reads.
//   Each address/data pair is then held for display. A pair advances either
//   after a dwell period (auto mode) or on a step request (step mode).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a scan (sampled in IDLE only)
//   stop         abort a scan; forces IDLE on the next edge
//   step_mode    0 = auto advance after dwell, 1 = advance on step
//   step         single-cycle advance request (step mode, HOLD only)
//   start_addr   first address of the scan
//   end_addr     last address of the scan (inclusive)
//   mem_addr     read address to the data memory
//   mem_rd_data  read data from the data memory
//   cur_addr     address of the word currently displayed
//   cur_data     data of the word currently displayed
//   data_valid   one-cycle pulse when cur_addr/cur_data update
//   busy         high whenever the engine is not IDLE
//   done         one-cycle pulse after the last word's HOLD completes
//
// Handshake: there is no back-pressure. data_valid is a qualifier pulse only:
// cur_addr/cur_data are new in exactly the cycle data_valid is high, and they
// stay stable until the next pulse. step is a one-shot request. It is consumed
// only in HOLD in step mode and is never queued.
module mem_scan_reader #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0]  mem_rd_data,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic [WORD_SIZE-1:0]  cur_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  // Counters only need to reach LIMIT-1, so $clog2(LIMIT) bits are enough.
  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(READ_LATENCY - 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // state is a plain named register so that checkers can bind to it directly.
  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] end_reg;
  logic                  mode_step;
  logic [WCW-1:0]        wait_cnt;
  logic [DCW-1:0]        dwell_cnt;
  logic                  hold_exit;

  assign busy = (state != S_IDLE);

  // HOLD releases on step (step mode) or on the final dwell cycle (auto mode).
  assign hold_exit = mode_step ? step : (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      end_reg    <= '0;
      mode_step  <= 1'b0;
      wait_cnt   <= '0;
      dwell_cnt  <= '0;
      mem_addr   <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      if (state != S_IDLE && stop) begin
        // Abort: the displayed word and mem_addr are left as they are.
        state     <= S_IDLE;
        wait_cnt  <= '0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              ptr       <= start_addr;
              end_reg   <= end_addr;
              mode_step <= step_mode;
              mem_addr  <= start_addr;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              cur_data   <= mem_rd_data;
              cur_addr   <= ptr;
              data_valid <= 1'b1;
              wait_cnt   <= '0;
              dwell_cnt  <= '0;
              state      <= S_HOLD;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (hold_exit) begin
              dwell_cnt <= '0;
              if (ptr == end_reg) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                // Natural wrap at the top of the address space.
                ptr      <= ptr + 1'b1;
                mem_addr <= ptr + 1'b1;
                state    <= S_ISSUE;
              end
            end else if (!mode_step) begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Bench for mem_scan_reader: a synchronous RAM model, directed scenarios and
// randomized scans, scored against expected word/cycle queues that are built
// from the range arithmetic and the per-word period.
module tb_mem_scan_reader;

  localparam int AW     = 8;
  localparam int W      = 8;
  localparam int RL     = 1;
  localparam int DW     = 4;
  localparam int PERIOD = 1 + RL + DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data;
  logic [AW-1:0] cur_addr;
  logic [W-1:0]  cur_data;
  logic          data_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mem_scan_reader #(
    .WORD_SIZE(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .DWELL_CYCLES(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .step_mode(step_mode), .step(step), .start_addr(start_addr),
    .end_addr(end_addr), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .cur_addr(cur_addr), .cur_data(cur_data), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  // RAM model: the read data appears RL edges after the address is sampled.
  logic [W-1:0] mem [256];
  logic [W-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[RL-1];

  // e counts rising edges; a value observed at a negedge belongs to edge e.
  int e = 0;
  always @(posedge clk) e <= e + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [AW+W-1:0] exp_q[$];
  int              exp_e_q[$];
  logic [AW+W-1:0] got_q[$];
  int              got_e_q[$];
  int              done_e_q[$];
  logic [AW+W-1:0] prev_cur = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Monitor: collects display updates and done pulses.
  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back({cur_addr, cur_data});
      got_e_q.push_back(e);
    end
    if (done) begin
      done_e_q.push_back(e);
      check("busy_low_with_done", busy, 0);
    end
    if (rst_n && ({cur_addr, cur_data} !== prev_cur))
      check("cur_change_needs_dv", data_valid, 1);
    prev_cur = {cur_addr, cur_data};
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_e_q.delete();
    got_q.delete(); got_e_q.delete(); done_e_q.delete();
  endtask

  function automatic int nwords(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    logic [AW-1:0] diff;
    diff = ea - sa;
    return int'(diff) + 1;
  endfunction

  task automatic fill_xor();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  // Pulses start for one edge and returns the number of the edge that samples it.
  task automatic launch(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                        input logic mode, output int n);
    start_addr = sa;
    end_addr   = ea;
    step_mode  = mode;
    start      = 1'b1;
    n          = e + 1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("mem_addr_after_start", mem_addr, sa);
  endtask

  task automatic compare_sb();
    check("dv_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check("word", got_q.pop_front(), exp_q.pop_front());
      check("dv_cycle", got_e_q.pop_front(), exp_e_q.pop_front());
    end
  endtask

  task automatic run_auto(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    int n, k;
    logic [AW-1:0] a;
    clear_sb();
    launch(sa, ea, 1'b0, n);
    k = nwords(sa, ea);
    for (int i = 0; i < k; i++) begin
      a = sa + 8'(i);
      exp_q.push_back({a, mem[a]});
      exp_e_q.push_back(n + 1 + RL + i * PERIOD);
    end
    for (int t = 0; t < k * PERIOD + 10 && done_e_q.size() == 0; t++) tick();
    tick();
    check("auto_done_count", done_e_q.size(), 1);
    if (done_e_q.size() > 0) check("auto_done_cycle", done_e_q[0], n + k * PERIOD);
    check("auto_busy_after", busy, 0);
    compare_sb();
  endtask

  task automatic run_step(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    int n, k, m, next_e, done_exp;
    logic [AW-1:0] a;
    clear_sb();
    launch(sa, ea, 1'b1, n);
    step_mode = 1'b0;  // the mode latched at start must stay in force
    k = nwords(sa, ea);
    next_e = n + 1 + RL;
    done_exp = -1;
    for (int i = 0; i < k; i++) begin
      a = sa + 8'(i);
      exp_q.push_back({a, mem[a]});
      exp_e_q.push_back(next_e);
      for (int t = 0; t < 20 && got_q.size() < i + 1; t++) tick();
      check("step_dv_seen", got_q.size(), i + 1);
      repeat ($urandom_range(1, 5)) tick();
      check("step_no_advance", got_q.size(), i + 1);
      check("step_busy_in_hold", busy, 1);
      step = 1'b1;
      m = e + 1;
      tick();
      step = 1'b0;
      if (i < k - 1) begin
        tick();              // now in WAIT: this step must be ignored
        step = 1'b1;
        tick();
        step = 1'b0;
        next_e = m + 2;
      end else begin
        done_exp = m;
      end
    end
    tick();
    check("step_done_count", done_e_q.size(), 1);
    if (done_e_q.size() > 0) check("step_done_cycle", done_e_q[0], done_exp);
    compare_sb();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] sa, ea;
    int n;
    fill_xor();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cur_addr", cur_addr, 0);
    check("rst_cur_data", cur_data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Directed scans.
    run_auto(8'h10, 8'h13);
    run_auto(8'hFE, 8'h01);
    run_auto(8'h42, 8'h42);
    run_step(8'h00, 8'h02);

    // Stop in the second HOLD.
    clear_sb();
    launch(8'h10, 8'h13, 1'b0, n);
    for (int t = 0; t < 3 * PERIOD && got_q.size() < 2; t++) tick();
    check("stop_reached_hold2", got_q.size(), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_cur_addr", cur_addr, 8'h11);
    check("stop_cur_data", cur_data, mem[8'h11]);
    repeat (DW + 4) tick();
    check("stop_no_done", done_e_q.size(), 0);
    check("stop_no_more_dv", got_q.size(), 2);
    check("stop_cur_addr_kept", cur_addr, 8'h11);
    check("stop_mem_addr_kept", mem_addr, 8'h11);

    // start and stop together in IDLE.
    start_addr = 8'h30;
    end_addr   = 8'h31;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    tick();
    check("start_stop_busy", busy, 0);
    check("start_stop_mem_addr", mem_addr, 8'h11);
    start = 1'b0;
    stop  = 1'b0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    clear_sb();
    launch(8'h20, 8'h22, 1'b0, n);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_cur_addr", cur_addr, 0);
    check("arst_cur_data", cur_data, 0);
    check("arst_data_valid", data_valid, 0);
    check("arst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_auto(8'h05, 8'h07);

    // Randomized scans with random memory contents.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      sa = 8'($urandom_range(0, 255));
      ea = sa + 8'($urandom_range(0, 5));
      if (r % 3 == 2) run_step(sa, ea);
      else            run_auto(sa, ea);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
